// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stream carried between pipeline stages.
// The master drives valid/data, the slave drives ready.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32
) ();
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional two-entry skid buffer.
// SKID=0: single entry, ready is combinational from downstream ready.
// SKID=1: main + skid entries, ready is a register output so the
//         downstream ready never reaches upstream combinationally.
// flush squashes everything held plus the item offered that cycle.
// stall_cnt_o saturates on cycles where an item waits on downstream.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    pipe_stage_reg_if.slave  up_i,
    pipe_stage_reg_if.master dn_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic out_valid;
    logic in_ready;
    logic in_fire;
    logic out_fire;
    logic ld_main_in;
    logic ld_main_skid;
    logic ld_skid;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = up_i.valid && in_ready && !flush_i;
    assign out_fire  = out_valid && dn_o.ready;

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;

            // Ready tracks whether a slot will be free after this edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != ST_TWO);
                end
            end

            // Upstream drops its squashed item during flush, so ready is forced high.
            assign in_ready = in_ready_q || flush_i;

            // The registered ready must always mirror "not full".
            a_ready_mirrors_state: assert property (
                @(posedge clk) disable iff (rst) in_ready_q == (state_q != ST_TWO));
        end else begin : g_noskid
            // A single entry can accept whenever it is empty or being drained.
            assign in_ready = !out_valid || dn_o.ready || flush_i;

            // Without a skid slot the second entry must never be used.
            a_no_two: assert property (
                @(posedge clk) disable iff (rst) state_q != ST_TWO);
        end
    endgenerate

    assign up_i.ready  = in_ready;
    assign dn_o.valid  = out_valid;
    assign dn_o.data   = main_q;
    assign stall_cnt_o = stall_cnt_q;

    // A full stage must never accept another item.
    a_no_accept_full: assert property (
        @(posedge clk) disable iff (rst) (state_q == ST_TWO) |-> !in_fire);

    // State register: occupancy plus datapath and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next occupancy: flush wins over every transfer.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) state_d = ST_ONE;
                end
                ST_ONE: begin
                    if (in_fire && !out_fire && (SKID != 0)) state_d = ST_TWO;
                    else if (!in_fire && out_fire)           state_d = ST_EMPTY;
                end
                ST_TWO: begin
                    if (out_fire) state_d = ST_ONE;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Load strobes: which register captures what on this edge.
    always_comb begin
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (!flush_i) begin
            case (state_q)
                ST_EMPTY: ld_main_in = in_fire;
                ST_ONE: begin
                    // Simultaneous in/out replaces main; input alone parks in skid.
                    ld_main_in = in_fire && out_fire;
                    ld_skid    = in_fire && !out_fire && (SKID != 0);
                end
                ST_TWO:   ld_main_skid = out_fire;
                default: ;
            endcase
        end
    end

    // Data next-state: registers hold bit-identical unless strobed.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (ld_main_in)        main_d = up_i.data;
        else if (ld_main_skid) main_d = skid_q;
        if (ld_skid)           skid_d = up_i.data;
    end

    // Stall counter: saturating, independent of flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !dn_o.ready && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the payload carried between stages.
REQ-002 Parameter SKID, default 1: 0 = single entry with combinational ready; 1 = two-entry skid buffer with registered ready.
REQ-003 Parameter CNT_W, default 16, width of the stall counter.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  upstream offers an item this cycle.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 in_ready  output  1  stage accepts the offered item this cycle.
REQ-009 out_valid  output  1  stage holds a valid item for downstream.
REQ-010 out_data  output  DATA_W  payload of the oldest held item.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 flush  input  1  squash all held items and any item offered this cycle.
REQ-013 stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-014 An input transfer occurs when in_valid && in_ready && !flush; an output transfer occurs when out_valid && out_ready.
REQ-015 Items SHALL leave in strict arrival order; no item is duplicated or lost except by flush.
REQ-016 Occupancy states: EMPTY (0 items), ONE (1 item in main), TWO (main + skid, SKID=1 only); out_valid=1 in ONE and TWO; out_data always equals main.
REQ-017 SKID=0: in_ready = !out_valid || out_ready (combinational from out_ready); input transfer loads main next edge, state ONE.
REQ-018 SKID=0: output transfer without input transfer moves ONE->EMPTY; no transfer holds main unchanged.
REQ-019 SKID=1: in_ready is a register output, 1 in EMPTY and ONE, 0 in TWO; no combinational path from out_ready to in_ready.
REQ-020 SKID=1 EMPTY: input transfer -> ONE, main<=in_data.
REQ-021 SKID=1 ONE: input+output transfer -> ONE, main<=in_data; input only -> TWO, skid<=in_data; output only -> EMPTY; neither -> hold.
REQ-022 SKID=1 TWO: output transfer -> ONE, main<=skid; otherwise hold; in_ready=0 so no input transfer.
REQ-023 Latency: item accepted at edge N is visible on out_data/out_valid after edge N (one cycle) when the stage was EMPTY or drained that cycle.
REQ-024 While no transfer occurs, main, skid and out_data SHALL remain bit-identical.
REQ-025 flush=1 (rst=0): next edge state -> EMPTY, out_valid=0, in_ready=1; offered item dropped; flush overrides all transfers; data registers need not change.
REQ-026 in_ready SHALL also be 1 during a flush cycle in both modes, so upstream drops its squashed item in the same cycle.
REQ-027 stall_cnt increments by 1 on each edge where out_valid=1 and out_ready=0, saturates at 2^CNT_W-1, is unaffected by flush.
REQ-028 Arithmetic is unsigned; stall_cnt never wraps.

Reset
REQ-029 rst has priority over flush and all transfers.
REQ-030 After rst: state EMPTY, out_valid=0, out_data=0, skid=0, stall_cnt=0, in_ready=1 (both modes).
REQ-031 rst asserted mid-operation (ONE or TWO) discards all held items at that edge.

Verification
REQ-032 SKID=1, out_ready=1, in_valid=1 with data 1,2,3 on consecutive cycles -> out_data 1,2,3 one cycle later each, out_valid continuous, in_ready=1 throughout.
REQ-033 SKID=1, out_ready=0, offer 0xA then 0xB -> state TWO, in_ready=0, out_data=0xA held; raise out_ready -> 0xA then 0xB emitted, in_ready=1 after first drain.
REQ-034 SKID=0, out_valid=1, out_ready=0 -> in_ready=0 same cycle; out_ready=1 with in_valid=1 -> in_ready=1 same cycle, item replaces main.
REQ-035 TWO state holding 0x5,0x6, assert flush one cycle with in_valid=1 data 0x7 -> next cycle out_valid=0, 0x7 never emitted, in_ready=1.
REQ-036 CNT_W=2, out_valid=1, out_ready=0 for 5 cycles -> stall_cnt 1,2,3,3,3; rst -> 0.
REQ-037 rst asserted together with flush and in_valid=1 -> all outputs at REQ-030 values next cycle.
